// File: rtl/dmem_responder_pkg.sv
// dmem_responder shared constants: funct3 codes, FSM states, default latency.
// Optional misaligned-access checking is enabled by DMEM_MISALIGN_CHECK_EN.
`ifndef MEM_DELAY_CONST
`define MEM_DELAY_CONST 4
`endif

package dmem_responder_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int MEM_DELAY = `MEM_DELAY_CONST;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } acc_size_t;

  // Undefined encodings fall back to a full-word access.
  function automatic acc_size_t acc_size(
    input logic [2:0] f3,
    input logic       wr
  );
    acc_size_t s;
    s = SZ_W;
    if (wr) begin
      if (f3 == F3_SB) s = SZ_B;
      else if (f3 == F3_SH) s = SZ_H;
    end else begin
      if (f3[1:0] == 2'b00) s = SZ_B;
      else if (f3[1:0] == 2'b01) s = SZ_H;
    end
    return s;
  endfunction

endpackage

// File: rtl/dmem_responder_load_extend.sv
// dmem_load_extend: lane select and sign/zero extension of a load word.
// Misaligned lanes are treated as aligned; the top masks them when checking.
module dmem_load_extend
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    data = word;
    unique case (1'b1)
      (funct3 == F3_LB):  data = {{24{b[7]}}, b};
      (funct3 == F3_LBU): data = {24'b0, b};
      (funct3 == F3_LH):  data = {{16{h[15]}}, h};
      (funct3 == F3_LHU): data = {16'b0, h};
      default:            data = word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory behind the CU DRAM_RE/DRAM_WE port.
// Define DMEM_MISALIGN_CHECK_EN to flag and suppress misaligned accesses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = `MEM_DELAY_CONST
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        re,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int         DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] LAST  = 4'(LATENCY - 1);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_responder: LATENCY %0d outside 1..15", LATENCY);
    end
  endgenerate

  dmem_state_t state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        accept;

  logic [ADDR_W-1:0] q_idx;
  logic [1:0]        q_lane;
  logic [31:0]       q_wdata;
  logic [2:0]        q_f3;
  logic              q_wr;

  logic [31:0] mem [DEPTH];
  logic [31:0] mem_word;
  logic [31:0] ld_data;
  logic [31:0] lane_data;
  logic [3:0]  be;
  acc_size_t   q_sz;
  logic        mis;
  logic        commit;
  logic        unused_addr;

  assign unused_addr = ^addr[31:ADDR_W+2];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (re | we) begin
          accept  = 1'b1;
          cnt_n   = 4'd1;
          state_n = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt + 4'd1;
        if (cnt == LAST) state_n = RESP;
      end
      RESP: begin
        cnt_n   = 4'd0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      q_idx   <= '0;
      q_lane  <= 2'd0;
      q_wdata <= 32'd0;
      q_f3    <= 3'd0;
      q_wr    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        q_idx   <= addr[ADDR_W+1:2];
        q_lane  <= addr[1:0];
        q_wdata <= wdata;
        q_f3    <= funct3;
        q_wr    <= we;
      end
    end
  end

  assign q_sz = acc_size(q_f3, q_wr);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign mis = ((q_sz == SZ_H) && q_lane[0]) ||
               ((q_sz == SZ_W) && (q_lane != 2'd0));
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    be        = 4'hF;
    lane_data = q_wdata;
    case (q_sz)
      SZ_B: begin
        be        = 4'b0001 << q_lane;
        lane_data = {4{q_wdata[7:0]}};
      end
      SZ_H: begin
        be        = q_lane[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{q_wdata[15:0]}};
      end
      default: begin
        be        = 4'hF;
        lane_data = q_wdata;
      end
    endcase
  end

  // The store lands on the edge that closes RESP.
  assign commit = (state == RESP) & q_wr & ~mis;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[q_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  assign mem_word = mem[q_idx];

  dmem_load_extend u_ext (
    .word   (mem_word),
    .lane   (q_lane),
    .funct3 (q_f3),
    .data   (ld_data)
  );

  assign stall  = nrst & (((state == IDLE) & (re | we)) | (state == WAIT));
  assign rvalid = (state == RESP);
  assign err    = (state == RESP) & mis;
  assign rdata  = ((state == RESP) & ~q_wr & ~mis) ? ld_data : 32'd0;

endmodule
